pcm_sample_fifo: RTL

PCM_SAMPLE_FIFO -- requirements
Module: pcm_sample_fifo

---
 rtl/pdm_pkg.sv | 19 +
 rtl/pcm_dc_blocker.sv | 47 ++++
 rtl/pcm_sample_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/pdm_pkg.sv
// Shared PCM types and helpers for the sample FIFO and its optional DC blocker.
// The DC blocker path is built only when PCM_DCBLOCK_EN is defined.
package pdm_pkg;
  localparam int PCM_WIDTH = 16;
  localparam int PCM_MAX   = (2 ** (PCM_WIDTH - 1)) - 1;

  typedef logic signed [PCM_WIDTH-1:0] pcm_t;

  // Clamp a 32-bit signed intermediate into the PCM range instead of wrapping.
  function automatic pcm_t sat_pcm(input logic signed [31:0] v);
    if (v > PCM_MAX) begin
      return {1'b0, {(PCM_WIDTH - 1){1'b1}}};
    end else if (v < -PCM_MAX - 1) begin
      return {1'b1, {(PCM_WIDTH - 1){1'b0}}};
    end else begin
      return v[PCM_WIDTH-1:0];
    end
  endfunction
endpackage

// File: rtl/pcm_dc_blocker.sv
// First-order DC blocker: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
// Exists only when PCM_DCBLOCK_EN is defined; samples are PCM_WIDTH wide.
`ifdef PCM_DCBLOCK_EN
module pcm_dc_blocker
  import pdm_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic in_valid,
  input  pcm_t in_pcm,
  output logic out_valid,
  output pcm_t out_pcm
);
  logic signed [31:0] x_prev;
  logic signed [31:0] y_prev;
  logic signed [31:0] x_cur;
  logic signed [31:0] y_next;

  assign x_cur  = {{(32 - PCM_WIDTH){in_pcm[PCM_WIDTH-1]}}, in_pcm};
  // Feedback keeps full 32-bit precision; only the stored sample is clamped.
  assign y_next = x_cur - x_prev + y_prev - (y_prev >>> DC_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_prev    <= '0;
      y_prev    <= '0;
      out_valid <= 1'b0;
      out_pcm   <= '0;
    end else if (clear) begin
      x_prev    <= '0;
      y_prev    <= '0;
      out_valid <= 1'b0;
      out_pcm   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        x_prev  <= x_cur;
        y_prev  <= y_next;
        out_pcm <= sat_pcm(y_next);
      end
    end
  end
endmodule
`endif

// File: rtl/pcm_sample_fifo.sv
// Circular PCM sample FIFO with first-word-fall-through output and drop accounting.
// Define PCM_DCBLOCK_EN to insert the DC blocker ahead of storage (one extra cycle).
module pcm_sample_fifo
  import pdm_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH       = 256,
  parameter int AFULL_LEVEL = 192,
  parameter int DC_SHIFT    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    in_pcm,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [15:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  pop;
  logic                  full;
  logic                  push;
  logic                  drop;

`ifdef PCM_DCBLOCK_EN
  // Blocker is PCM_WIDTH wide, so DATA_WIDTH must match PCM_WIDTH in this build.
  pcm_t dc_out;

  pcm_dc_blocker #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_blocker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_pcm    (pcm_t'(in_pcm)),
    .out_valid (wr_valid),
    .out_pcm   (dc_out)
  );

  assign wr_data = dc_out;
`else
  assign wr_valid = in_valid;
  assign wr_data  = in_pcm;
`endif

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign pop  = (level_q != '0) && out_ready;
  assign full = (level_q == LW'(DEPTH));
  assign push = wr_valid && (!full || pop);
  assign drop = wr_valid && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wr_data;
  end

  assign level       = level_q;
  assign out_valid   = (level_q != '0);
  // Gate the head so an empty FIFO always presents zero rather than stale data.
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign almost_full = (level_q >= LW'(AFULL_LEVEL));
endmodule
